// File: rtl/decode_regread_stage_if.sv
// decode_regread_stage_if: fetch-side, regfile, execute-side and scoreboard-clear signals of the decode stage
interface decode_regread_stage_if #(parameter int XLEN = 16);
  logic in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_instr;
  logic [3:0] raddr0_, raddr1_;
  logic [XLEN-1:0] rdata0, rdata1;
  logic out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_instr, out_opa, out_opb;
  logic out_wen, out_illegal;
  logic sb_clr_en;
  logic [3:0] sb_clr_addr;
  logic flush;
  modport slave (
    input in_valid, in_pc, in_instr, rdata0, rdata1, out_ready, sb_clr_en, sb_clr_addr, flush,
    output in_ready, raddr0_, raddr1_, out_valid, out_pc, out_instr, out_opa, out_opb, out_wen, out_illegal
  );
  modport master (
    output in_valid, in_pc, in_instr, rdata0, rdata1, out_ready, sb_clr_en, sb_clr_addr, flush,
    input in_ready, raddr0_, raddr1_, out_valid, out_pc, out_instr, out_opa, out_opb, out_wen, out_illegal
  );
endinterface

// File: rtl/decode_regread_stage.sv
// decode_regread_stage: decode, register read and scoreboard hazard check between fetch and execute
module decode_regread_stage #(
  parameter int XLEN = 16,
  parameter int NREGS = 16
) (
  input logic clk,
  input logic reset,
  decode_regread_stage_if.slave bus
);
  logic dec_valid;
  logic [XLEN-1:0] pc, instr;
  logic [NREGS-1:0] sb, sb_next;
  logic [3:0] op, ra, rb, rt;
  logic e_ok, f_ld, f_st, use_a, use_b, writes, wen, hazard, issue;
  assign {op, ra, rb, rt} = instr[15:0];
  assign e_ok = op == 4'he && rb[3:2] == 2'd0;
  assign f_ld = op == 4'hf && rb == 4'd0;
  assign f_st = op == 4'hf && rb == 4'd1;
  assign use_a = op == 4'h0 || e_ok || f_ld || f_st;
  assign use_b = op == 4'h0 || op == 4'h9 || e_ok || f_st;
  assign writes = op == 4'h0 || op == 4'h8 || op == 4'h9 || f_ld;
  assign wen = writes && rt != 4'd0;
  assign bus.raddr0_ = use_a ? ra : 4'd0;
  assign bus.raddr1_ = use_b ? (op == 4'h0 ? rb : rt) : 4'd0;
  // r0 never gets set, so unused ports reading address 0 never raise a hazard
  assign hazard = dec_valid && (sb[bus.raddr0_] || sb[bus.raddr1_] || (wen && sb[rt]));
  assign issue = dec_valid && !hazard && (!bus.out_valid || bus.out_ready);
  assign bus.in_ready = !dec_valid || issue;
  // scoreboard update: clears first so a same-cycle set of the same bit wins
  always_comb begin
    sb_next = sb;
    if (bus.sb_clr_en) sb_next[bus.sb_clr_addr] = 1'b0;
    if (bus.flush && bus.out_valid && bus.out_wen) sb_next[bus.out_instr[3:0]] = 1'b0;
    if (!bus.flush && issue && wen) sb_next[rt] = 1'b1;
  end
  // decode register, output bundle register and scoreboard
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_valid <= 1'b0;
      pc <= '0;
      instr <= '0;
      sb <= '0;
      bus.out_valid <= 1'b0;
      bus.out_pc <= '0;
      bus.out_instr <= '0;
      bus.out_opa <= '0;
      bus.out_opb <= '0;
      bus.out_wen <= 1'b0;
      bus.out_illegal <= 1'b0;
    end else begin
      sb <= sb_next;
      if (bus.flush) begin
        dec_valid <= 1'b0;
        bus.out_valid <= 1'b0;
      end else begin
        if (issue) begin
          bus.out_valid <= 1'b1;
          bus.out_pc <= pc;
          bus.out_instr <= instr;
          bus.out_opa <= bus.rdata0;
          bus.out_opb <= bus.rdata1;
          bus.out_wen <= wen;
          bus.out_illegal <= !(use_a || use_b || writes);
        end else if (bus.out_ready) bus.out_valid <= 1'b0;
        if (bus.in_valid && bus.in_ready) begin
          dec_valid <= 1'b1;
          pc <= bus.in_pc;
          instr <= bus.in_instr;
        end else if (issue) dec_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_decode_regread_stage.sv
// tb_decode_regread_stage: scoreboard bench with a rule-level decode model and a writeback model
module tb_decode_regread_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  decode_regread_stage_if bus ();
  decode_regread_stage dut (.clk(clk), .reset(reset), .bus(bus));

  logic [15:0] rf [16];
  assign bus.rdata0 = rf[bus.raddr0_];
  assign bus.rdata1 = rf[bus.raddr1_];

  typedef struct packed {
    logic [15:0] pc, instr, opa, opb;
    logic wen, ill;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int n_chk = 0, n_fail = 0, pops = 0, p0;
  int pend[16];
  logic [15:0] tb_pc = 16'd0;
  logic last_rdy;
  logic pce;
  logic [3:0] pca;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] pc, input logic [15:0] ins);
    exp_t m;
    logic [3:0] op, ra, rb, rt, a, b;
    logic w, ill;
    op = ins[15:12]; ra = ins[11:8]; rb = ins[7:4]; rt = ins[3:0];
    a = 4'd0; b = 4'd0; w = 1'b0; ill = 1'b0;
    case (op)
      4'h0: begin a = ra; b = rb; w = 1'b1; end
      4'h8: w = 1'b1;
      4'h9: begin b = rt; w = 1'b1; end
      4'he: if (rb < 4) begin a = ra; b = rt; end else ill = 1'b1;
      4'hf: if (rb == 0) begin a = ra; w = 1'b1; end
            else if (rb == 1) begin a = ra; b = rt; end
            else ill = 1'b1;
      default: ill = 1'b1;
    endcase
    m.pc = pc; m.instr = ins; m.opa = rf[a]; m.opb = rf[b];
    m.wen = w && rt != 0; m.ill = ill;
    return m;
  endfunction

  function automatic logic [15:0] rnd_instr();
    logic [3:0] ops [10] = '{4'h0, 4'h0, 4'h8, 4'h9, 4'he, 4'he, 4'hf, 4'hf, 4'h3, 4'hb};
    logic [15:0] r;
    r = 16'($urandom);
    r[15:12] = ops[$urandom_range(0, 9)];
    r[11:8] = 4'($urandom_range(0, 7));
    r[3:0] = 4'($urandom_range(0, 7));
    if (r[15:12] == 4'hf) r[7:4] = 4'($urandom_range(0, 2));
    else r[7:4] = 4'($urandom_range(0, 7));
    return r;
  endfunction

  // monitor: every presented bundle must match the oldest expected entry; a transfer pops it
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (q.size() == 0) chk("unexpected_out", bus.out_valid, 1'b0);
      else begin
        me = q[0];
        chk("out_pc", bus.out_pc, me.pc);
        chk("out_instr", bus.out_instr, me.instr);
        chk("out_opa", bus.out_opa, me.opa);
        chk("out_opb", bus.out_opb, me.opb);
        chk("out_wen", bus.out_wen, me.wen);
        chk("out_illegal", bus.out_illegal, me.ill);
        if (bus.out_ready && !bus.flush) begin
          void'(q.pop_front());
          pops++;
          if (me.wen) pend[me.instr[3:0]]++;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [15:0] ins, input logic ordy = 1'b1,
                     input logic fl = 1'b0, input logic ce = 1'b0, input logic [3:0] ca = 4'd0);
    bus.in_valid = v; bus.in_instr = ins; bus.in_pc = tb_pc; bus.out_ready = ordy;
    bus.flush = fl; bus.sb_clr_en = ce; bus.sb_clr_addr = ca;
    @(negedge clk); #1;
    last_rdy = bus.in_ready;
    if (fl) q.delete();
    else if (v && bus.in_ready) begin
      q.push_back(model(tb_pc, ins));
      tb_pc += 16'd2;
    end
    if (ce && pend[ca] > 0) pend[ca]--;
    @(posedge clk); #1;
  endtask

  task automatic pick();
    int s;
    s = $urandom_range(0, 15);
    pce = 1'b0; pca = 4'd0;
    for (int j = 0; j < 16; j++)
      if (!pce && pend[(s + j) % 16] > 0) begin
        pce = 1'b1;
        pca = 4'((s + j) % 16);
      end
  endtask

  task automatic drain();
    int left;
    for (int c = 0; c < 300; c++) begin
      left = 0;
      foreach (pend[i]) left += pend[i];
      if (q.size() == 0 && left == 0) break;
      pick();
      cyc(1'b0, 16'd0, 1'b1, 1'b0, pce, pca);
    end
    left = 0;
    foreach (pend[i]) left += pend[i];
    chk("drain_queue", q.size(), 0);
    chk("drain_pending", left, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = 16'd0; bus.in_pc = 16'd0; bus.out_ready = 1'b1;
    bus.flush = 1'b0; bus.sb_clr_en = 1'b0; bus.sb_clr_addr = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    foreach (pend[i]) pend[i] = 0;
    tb_pc = 16'd0;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_pc", bus.out_pc, 16'd0);
    chk("rst_out_instr", bus.out_instr, 16'd0);
    chk("rst_out_ops", {bus.out_opa, bus.out_opb}, 32'd0);
    chk("rst_out_flags", {bus.out_wen, bus.out_illegal}, 2'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (rf[i]) rf[i] = 16'($urandom);
    rf[5] = 16'h0042;
    do_reset();
    // straight line
    p0 = pops;
    cyc(1'b1, 16'h8105); chk("line_acc0", last_rdy, 1'b1);
    cyc(1'b1, 16'h8206); chk("line_acc1", last_rdy, 1'b1);
    cyc(1'b1, 16'h0123); chk("line_acc2", last_rdy, 1'b1);
    cyc(1'b0, 16'd0); cyc(1'b0, 16'd0);
    chk("line_pops", pops - p0, 3);
    drain();
    // RAW on r5
    cyc(1'b1, 16'h8105);
    cyc(1'b1, 16'h0453); chk("raw_acc", last_rdy, 1'b1);
    repeat (3) begin cyc(1'b0, 16'd0); chk("raw_stall", last_rdy, 1'b0); end
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 4'd5); chk("raw_stall_clr", last_rdy, 1'b0);
    cyc(1'b0, 16'd0); chk("raw_go", last_rdy, 1'b1);
    cyc(1'b0, 16'd0);
    drain();
    // WAW on r7, then r0 writers never stall
    cyc(1'b1, 16'h8107);
    cyc(1'b1, 16'h8207); chk("waw_acc", last_rdy, 1'b1);
    repeat (2) begin cyc(1'b0, 16'd0); chk("waw_stall", last_rdy, 1'b0); end
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 4'd7); chk("waw_stall_clr", last_rdy, 1'b0);
    cyc(1'b0, 16'd0); chk("waw_go", last_rdy, 1'b1);
    repeat (3) begin cyc(1'b1, 16'h0000); chk("r0_nostall", last_rdy, 1'b1); end
    drain();
    // backpressure
    p0 = pops;
    cyc(1'b1, 16'h8101);
    cyc(1'b1, 16'h8202, 1'b0);
    repeat (3) begin cyc(1'b1, 16'h8303, 1'b0); chk("bp_in_ready", last_rdy, 1'b0); end
    for (int c = 0; c < 10; c++) begin
      cyc(1'b1, 16'h8303);
      if (last_rdy) break;
    end
    chk("bp_accept", last_rdy, 1'b1);
    drain();
    chk("bp_pops", pops - p0, 3);
    // flush with a pending writer in the output register
    cyc(1'b1, 16'h8109);
    cyc(1'b1, 16'h0193, 1'b0);
    cyc(1'b1, 16'h8404, 1'b0, 1'b1);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_in_ready", bus.in_ready, 1'b1);
    cyc(1'b1, 16'h0190); chk("flush_acc", last_rdy, 1'b1);
    cyc(1'b0, 16'd0); chk("flush_nostall", last_rdy, 1'b1);
    drain();
    // illegal encoding
    cyc(1'b1, 16'h3000);
    cyc(1'b1, 16'he480);
    drain();
    // reset during a stall
    cyc(1'b1, 16'h8105, 1'b0);
    cyc(1'b1, 16'h8205, 1'b0);
    cyc(1'b0, 16'd0, 1'b0); chk("rst_stall", last_rdy, 1'b0);
    do_reset();
    cyc(1'b1, 16'h8205);
    cyc(1'b0, 16'd0); chk("rst_sb_clear", last_rdy, 1'b1);
    drain();
    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      pick();
      if ($urandom_range(0, 2) == 0) pce = 1'b0;
      cyc($urandom_range(0, 3) != 0, rnd_instr(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 40) == 0, pce, pca);
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_regread_stage.md
Name: decode_regread_stage

Overview:
- Pipeline stage directly downstream of fetch stage F1.
- Accepts the fetched instruction and its PC, and decodes fields opcode[15:12], ra[11:8], rb[7:4], rt[3:0].
- Reads operands from the register file and blocks RAW/WAW hazards with a 16-entry scoreboard.
- Hands a decoded, operand-carrying bundle to the execute stage through a valid/ready handshake. Flush from execute squashes the younger instructions this stage holds.

Parameters:
- XLEN, 16, data/instruction/PC width.
- NREGS, 16, register count; the scoreboard has NREGS bits.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, F1 presents an instruction.
- in_ready, output, 1, stage can accept this cycle.
- in_pc, input, XLEN, PC of the incoming instruction.
- in_instr, input, XLEN, incoming instruction word.
- raddr0_, output, 4, register file read port 0 address (source A).
- rdata0, input, XLEN, port 0 data; combinational read.
- raddr1_, output, 4, register file read port 1 address (source B).
- rdata1, input, XLEN, port 1 data; combinational read.
- out_valid, output, 1, bundle valid to execute.
- out_ready, input, 1, execute accepts the bundle.
- out_pc, output, XLEN, PC of the bundle.
- out_instr, output, XLEN, raw instruction.
- out_opa, output, XLEN, source A value.
- out_opb, output, XLEN, source B value.
- out_wen, output, 1, instruction writes out_instr[3:0] (rt) and rt != 0.
- out_illegal, output, 1, undefined encoding.
- sb_clr_en, input, 1, writeback retires a pending write.
- sb_clr_addr, input, 4, register retired.
- flush, input, 1, squash all instructions held in this stage.

Behaviour:
- Decode (sources -> A/B, write rt):
  - op 0 sub: A=ra, B=rb, writes rt.
  - op 8 movl: no sources, writes rt.
  - op 9 movh: B=rt, writes rt.
  - op E jump: rb 0..3 legal; A=ra, B=rt; no write.
  - op F: rb=0 ld: A=ra, writes rt. rb=1 st: A=ra, B=rt, no write.
  - Anything else is illegal: no sources, no write, out_illegal=1.
- Unused read port address is 0. Register r0 is never a hazard and never sets the scoreboard.
- Internal registers:
  - D: dec_valid, pc, instr.
  - O: the out_* registers.
  - SB: NREGS-bit scoreboard.
- raddr0_/raddr1_ are driven combinationally from D.
- hazard = dec_valid && (SB[srcA] or SB[srcB] for used sources, or SB[rt] when writing).
- issue = dec_valid && !hazard && (!out_valid || out_ready).
- in_ready = !dec_valid || issue. It is combinational and must not depend on in_valid.
- On issue: O loads pc, instr, rdata0 into out_opa, rdata1 into out_opb, wen and illegal; out_valid<=1; if wen, SB[rt]<=1.
- When not issuing and out_ready && out_valid: out_valid<=0.
- D loads in_pc/in_instr when in_valid && in_ready; otherwise dec_valid<=0 if issued.
- Minimum latency: instruction accepted at edge N appears on out at edge N+1. Full throughput is 1 per cycle.
- Stall: D and O hold all values; out_* stay stable while out_valid && !out_ready.
- sb_clr_en clears SB[sb_clr_addr] at the edge. Hazard uses the registered SB, so a dependent instruction issues one cycle after the clear edge; there is no bypass.
- Simultaneous set and clear of the same bit: set wins.
- An instruction that reads its own rt (e.g. sub r1,r1,r1) is checked against SB before its own set.
- flush (priority over everything except reset):
  - dec_valid<=0, out_valid<=0; in_valid that cycle is dropped.
  - If out_valid && out_wen, SB[out rt]<=0 (the killed writer never retires).
  - sb_clr_en in the same cycle is still honoured.
- Reset: dec_valid=0, out_valid=0, SB=0, all out_* data = 0, in_ready=1 the cycle after reset.
- Reset mid-stall discards everything.
- SB is exact: WAW stall guarantees at most one pending writer per register.

Test Plan:
- Straight line, no dependencies: 0x8105 (movl r5), 0x8206 (movl r6), 0x0123 (sub r3,r1,r2), SB clear -> out_valid on consecutive cycles, out_pc 0,2,4, wen=1 each, no stall.
- RAW: 0x8105 (writes r5) then 0x0453 (sub r3,r4,r5) -> second holds with in_ready=0 until sb_clr_en (addr 5) edge; issues the next edge with out_opb = rdata1 value 0x0042.
- WAW plus r0 rule: 0x8107 then 0x8207 stalls until r7 is cleared. 0x0000 (sub r0) never sets SB and never stalls.
- Backpressure: out_ready=0 for 3 cycles with D full -> in_ready=0, out_* unchanged; release -> drains in order with no loss or duplication.
- Flush: out holds 0x8109 (movl r9, wen=1), D holds 0x0193, flush=1 -> both valids 0 and SB[9]=0. The next fetched 0x0190 issues without stall.
- Illegal and reset: 0x3000 -> out_illegal=1, wen=0. Assert reset during a stall -> out_valid=0, SB=0, in_ready=1 next cycle.
